// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-path constants and FSM encoding used by the fetch unit,
// instruction register and control unit.
package instruction_fetch_unit_pkg;

    localparam int unsigned IFU_ADDR_W   = 16;
    localparam int unsigned IFU_DATA_W   = 16;
    localparam int unsigned IFU_PC_STEP  = 2;
    localparam logic [15:0] IFU_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_timeout.sv
// Wait counter for an outstanding memory read; expired flags the last
// permitted waiting cycle so the FSM aborts on the edge the count reaches TIMEOUT.
module fetch_timeout_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, performs one req/ready memory read per
// fetch request and strobes the fetched word into the IR for one cycle.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned         ADDR_W   = IFU_ADDR_W,
    parameter int unsigned         DATA_W   = IFU_DATA_W,
    parameter int unsigned         PC_STEP  = IFU_PC_STEP,
    parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(IFU_RESET_PC),
    parameter int unsigned         TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_next,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] memData,
    output logic              IRWrite,
    output logic              fetch_done,
    output logic              fetch_err,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state, state_next;
    logic              tmo_expired;
    logic              abort;
    logic              finishing;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_pc;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != ST_REQ),
        .enable  ((state == ST_REQ) && !mem_ready),
        .expired (tmo_expired)
    );

    assign abort     = (state == ST_REQ) && !mem_ready && tmo_expired;
    assign finishing = (state == ST_WRITE) || abort;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fetch_req) state_next = ST_REQ;
            ST_REQ: begin
                if (mem_ready)        state_next = ST_WRITE;
                else if (tmo_expired) state_next = ST_IDLE;
            end
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = (state == ST_REQ);
        IRWrite    = (state == ST_WRITE);
        fetch_done = (state == ST_WRITE);
        busy       = (state != ST_IDLE);
    end

    assign mem_addr = pc;

    // Redirects seen while busy are parked and only take effect once the
    // in-flight fetch retires; a redirect on that very edge wins over the parked one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            memData    <= '0;
            fetch_err  <= 1'b0;
        end else begin
            fetch_err <= abort;
            if ((state == ST_REQ) && mem_ready) begin
                memData <= mem_rdata;
            end
            if (state == ST_IDLE) begin
                if (pc_load) pc <= pc_next;
            end else if (finishing) begin
                if (pc_load)                pc <= pc_next;
                else if (pend_valid)        pc <= pend_pc;
                else if (state == ST_WRITE) pc <= pc + ADDR_W'(PC_STEP);
                pend_valid <= 1'b0;
            end else if (pc_load) begin
                pend_valid <= 1'b1;
                pend_pc    <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table of single-cycle vectors
// followed by hand-written multi-cycle sequences (wait states, timeout, reset).
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_next;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] memData;
    logic        IRWrite;
    logic        fetch_done;
    logic        fetch_err;
    logic        busy;
    logic [15:0] pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .PC_STEP  (2),
        .RESET_PC (16'h0000),
        .TIMEOUT  (15)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .memData    (memData),
        .IRWrite    (IRWrite),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err),
        .busy       (busy),
        .pc         (pc)
    );

    typedef struct {
        logic        rn;
        logic        rq;
        logic        ld;
        logic [15:0] nx;
        logic        rdy;
        logic [15:0] rd;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_irw;
        logic        e_done;
        logic        e_err;
        logic        e_busy;
        logic [15:0] e_pc;
        logic [15:0] e_md;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic rn, rq, ld, input logic [15:0] nx,
                                input logic rdy, input logic [15:0] rd,
                                input logic e_rd, input logic [15:0] e_addr,
                                input logic e_irw, e_done, e_err, e_busy,
                                input logic [15:0] e_pc, e_md);
        vec_t v;
        v.rn = rn; v.rq = rq; v.ld = ld; v.nx = nx; v.rdy = rdy; v.rd = rd;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_irw = e_irw; v.e_done = e_done;
        v.e_err = e_err; v.e_busy = e_busy; v.e_pc = e_pc; v.e_md = e_md;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs for the next rising edge, then return at the following falling edge.
    task automatic apply(input logic rn, rq, ld, input logic [15:0] nx,
                         input logic rdy, input logic [15:0] rd);
        reset_n   = rn;
        fetch_req = rq;
        pc_load   = ld;
        pc_next   = nx;
        mem_ready = rdy;
        mem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic check_row(input string tag, input logic e_rd, input logic [15:0] e_addr,
                             input logic e_irw, e_done, e_err, e_busy,
                             input logic [15:0] e_pc, e_md);
        check({tag, ".mem_rd"},     {15'b0, mem_rd},     {15'b0, e_rd});
        if (e_rd) check({tag, ".mem_addr"}, mem_addr, e_addr);
        check({tag, ".IRWrite"},    {15'b0, IRWrite},    {15'b0, e_irw});
        check({tag, ".fetch_done"}, {15'b0, fetch_done}, {15'b0, e_done});
        check({tag, ".fetch_err"},  {15'b0, fetch_err},  {15'b0, e_err});
        check({tag, ".busy"},       {15'b0, busy},       {15'b0, e_busy});
        check({tag, ".pc"},         pc,                  e_pc);
        check({tag, ".memData"},    memData,             e_md);
    endtask

    initial begin
        int irw_count;
        int rd_cycles;

        vecs[0]  = mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,0,0,0,16'h0000,16'h0000);
        vecs[1]  = mk(1,1,0,16'h0000,0,16'h0000, 1,16'h0000,0,0,0,1,16'h0000,16'h0000);
        vecs[2]  = mk(1,0,0,16'h0000,1,16'h3333, 0,16'h0000,1,1,0,1,16'h0000,16'h3333);
        vecs[3]  = mk(1,0,0,16'h0000,0,16'h0000, 0,16'h0002,0,0,0,0,16'h0002,16'h3333);
        vecs[4]  = mk(1,1,0,16'h0000,0,16'h0000, 1,16'h0002,0,0,0,1,16'h0002,16'h3333);
        vecs[5]  = mk(1,0,1,16'h0040,0,16'h0000, 1,16'h0002,0,0,0,1,16'h0002,16'h3333);
        vecs[6]  = mk(1,0,0,16'h0000,1,16'h1234, 0,16'h0002,1,1,0,1,16'h0002,16'h1234);
        vecs[7]  = mk(1,0,0,16'h0000,0,16'h0000, 0,16'h0040,0,0,0,0,16'h0040,16'h1234);
        vecs[8]  = mk(1,1,0,16'h0000,0,16'h0000, 1,16'h0040,0,0,0,1,16'h0040,16'h1234);
        vecs[9]  = mk(1,0,0,16'h0000,1,16'hABCD, 0,16'h0040,1,1,0,1,16'h0040,16'hABCD);
        vecs[10] = mk(1,0,0,16'h0000,0,16'h0000, 0,16'h0042,0,0,0,0,16'h0042,16'hABCD);
        vecs[11] = mk(1,1,1,16'hFFFE,0,16'h0000, 1,16'hFFFE,0,0,0,1,16'hFFFE,16'hABCD);
        vecs[12] = mk(1,0,0,16'h0000,1,16'h5A5A, 0,16'hFFFE,1,1,0,1,16'hFFFE,16'h5A5A);
        vecs[13] = mk(1,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,0,0,0,16'h0000,16'h5A5A);
        vecs[14] = mk(1,1,0,16'h0000,0,16'h0000, 1,16'h0000,0,0,0,1,16'h0000,16'h5A5A);
        vecs[15] = mk(1,1,0,16'h0000,1,16'h0F0F, 0,16'h0000,1,1,0,1,16'h0000,16'h0F0F);
        vecs[16] = mk(1,1,0,16'h0000,0,16'h0000, 0,16'h0002,0,0,0,0,16'h0002,16'h0F0F);
        vecs[17] = mk(1,0,0,16'h0000,1,16'hDEAD, 0,16'h0002,0,0,0,0,16'h0002,16'h0F0F);

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].rn, vecs[i].rq, vecs[i].ld, vecs[i].nx, vecs[i].rdy, vecs[i].rd);
            check_row($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_irw,
                      vecs[i].e_done, vecs[i].e_err, vecs[i].e_busy, vecs[i].e_pc, vecs[i].e_md);
        end

        // Four wait states before mem_ready: read held at a constant address.
        irw_count = 0;
        apply(1,1,0,16'h0000,0,16'h0000);
        check_row("ws.req0", 1,16'h0002,0,0,0,1,16'h0002,16'h0F0F);
        for (int k = 0; k < 4; k++) begin
            apply(1,0,0,16'h0000,0,16'h0000);
            check_row($sformatf("ws.wait%0d", k), 1,16'h0002,0,0,0,1,16'h0002,16'h0F0F);
        end
        apply(1,0,0,16'h0000,1,16'hFFFF);
        if (IRWrite) irw_count++;
        check_row("ws.write", 0,16'h0002,1,1,0,1,16'h0002,16'hFFFF);
        apply(1,0,0,16'h0000,0,16'h0000);
        if (IRWrite) irw_count++;
        check_row("ws.idle", 0,16'h0004,0,0,0,0,16'h0004,16'hFFFF);
        check("ws.irw_pulses", 16'(irw_count), 16'd1);

        // Memory never answers: abort after 15 request cycles.
        irw_count = 0;
        rd_cycles = 0;
        apply(1,1,0,16'h0000,0,16'h0000);
        for (int k = 0; k < 40 && mem_rd; k++) begin
            rd_cycles++;
            if (IRWrite) irw_count++;
            apply(1,0,0,16'h0000,0,16'h0000);
        end
        check("tmo.req_cycles", 16'(rd_cycles), 16'd15);
        check("tmo.irw_pulses", 16'(irw_count), 16'd0);
        check_row("tmo.abort", 0,16'h0004,0,0,1,0,16'h0004,16'hFFFF);
        apply(1,0,0,16'h0000,0,16'h0000);
        check_row("tmo.after", 0,16'h0004,0,0,0,0,16'h0004,16'hFFFF);

        // Reset in the middle of a request discards it.
        apply(1,1,0,16'h0000,0,16'h0000);
        check_row("rst.req", 1,16'h0004,0,0,0,1,16'h0004,16'hFFFF);
        apply(0,0,0,16'h0000,1,16'h7777);
        check_row("rst.reset", 0,16'h0000,0,0,0,0,16'h0000,16'h0000);
        apply(1,0,0,16'h0000,1,16'h7777);
        check_row("rst.after", 0,16'h0000,0,0,0,0,16'h0000,16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
